// File: rtl/level_slew.sv
// -----------------------------------------------------------------------------
// level_slew
//
// Slew-rate limiter that sits between an encoder value and the PWM level input
// of one RGB mixer channel. Use one instance per channel. The output level
// moves one LSB at a time toward the registered target, and takes one step
// every rate+1 clock cycles. This gives smooth colour fades where a direct
// connection would jump.
//
// Ports:
//   clk        in   1        divided system clock (about 50 kHz)
//   reset      in   1        synchronous, active-high reset
//   target     in   WIDTH    desired level (encoder value output)
//   rate       in   RATE_W   step interval, one LSB step every rate+1 cycles
//   level      out  WIDTH    current slewed level (linear)
//   pwm_level  out  WIDTH    value for the pwm level port
//   settled    out  1        high while the ramp state is IDLE
//
// Build option:
//   LEVEL_SLEW_GAMMA_EN  When defined, pwm_level is registered as
//                        (level*level) >> WIDTH, and full scale maps to full
//                        scale. This adds one cycle of latency. When undefined,
//                        pwm_level is level.
// -----------------------------------------------------------------------------
module level_slew #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned RATE_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  target,
    input  logic [RATE_W-1:0] rate,
    output logic [WIDTH-1:0]  level,
    output logic [WIDTH-1:0]  pwm_level,
    output logic              settled
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        UP   = 2'b01,
        DOWN = 2'b10
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  target_q;
    logic [WIDTH-1:0]  level_q, level_d;
    logic [RATE_W-1:0] div_q, div_d;
    logic              below, above;
    logic              tick;

    assign below = (level_q < target_q);
    assign above = (level_q > target_q);

    // Direction comes from the live compare. The stale state register only
    // decides whether the prescaler keeps running.
    always_comb begin
        state_d = IDLE;
        if (below) begin
            state_d = UP;
        end else if (above) begin
            state_d = DOWN;
        end
    end

    // The prescaler runs only while the ramp keeps its direction. Entering
    // IDLE or turning around restarts the step interval from zero.
    always_comb begin
        div_d = '0;
        tick  = 1'b0;
        if ((state_q != IDLE) && (state_d == state_q)) begin
            if (div_q == rate) begin
                tick = 1'b1;
            end else begin
                div_d = div_q + RATE_W'(1);
            end
        end
    end

    // The step is also guarded by the live compare, so level never
    // overshoots the target and never wraps at either rail.
    always_comb begin
        level_d = level_q;
        if (tick) begin
            unique case (state_q)
                UP:      if (below) level_d = level_q + WIDTH'(1);
                DOWN:    if (above) level_d = level_q - WIDTH'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            target_q <= '0;
            level_q  <= '0;
            div_q    <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target;
            level_q  <= level_d;
            div_q    <= div_d;
        end
    end

    assign level   = level_q;
    assign settled = (state_q == IDLE);

`ifdef LEVEL_SLEW_GAMMA_EN
    logic [2*WIDTH-1:0] square;
    logic [WIDTH-1:0]   pwm_d, pwm_q;

    // The top half of the square approximates gamma 2. Full scale is pinned
    // so that a fully-on channel really reaches 100% duty.
    always_comb begin
        square = level_q * level_q;
        pwm_d  = WIDTH'(square >> WIDTH);
        if (level_q == {WIDTH{1'b1}}) begin
            pwm_d = {WIDTH{1'b1}};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_q <= '0;
        end else begin
            pwm_q <= pwm_d;
        end
    end

    assign pwm_level = pwm_q;
`else
    assign pwm_level = level_q;
`endif

endmodule

// File: tb/tb_level_slew.sv
// -----------------------------------------------------------------------------
// tb_level_slew
//
// Directed bench for level_slew (WIDTH = 8, RATE_W = 8). It contains a vector
// table for the basic ramp-up and slow ramp-down timing. It also contains
// hand-written sequences for the slow ramp, a reversal, both rails, a reset
// in mid-ramp, and the pwm_level mapping. Define LEVEL_SLEW_GAMMA_EN for both
// the RTL and this bench to check the gamma build.
// -----------------------------------------------------------------------------
module tb_level_slew;

    logic       clk;
    logic       reset;
    logic [7:0] target;
    logic [7:0] rate;
    logic [7:0] level;
    logic [7:0] pwm_level;
    logic       settled;

    int total;
    int bad;

    level_slew #(
        .WIDTH  (8),
        .RATE_W (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .target    (target),
        .rate      (rate),
        .level     (level),
        .pwm_level (pwm_level),
        .settled   (settled)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [7:0] tgt;
        logic [7:0] rt;
        logic [7:0] lvl;
        logic       stl;
    } vec_t;

    vec_t vecs [16];

`ifdef LEVEL_SLEW_GAMMA_EN
    function automatic logic [7:0] gamma(input logic [7:0] l);
        logic [15:0] p;
        p = l * l;
        if (l == 8'd255) return 8'd255;
        return p[15:8];
    endfunction
`endif

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Apply one clock edge, then let the outputs settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic wait_level(input logic [7:0] val, input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            step();
            if (level == val) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        bit         ok;
        int         c9, c8, cs, stl_at_c8, maxl, viol;
        bit         falling;
        logic [7:0] prev;
        logic [7:0] prev_exp;
        int         exp_pwm;

        total  = 0;
        bad    = 0;
        reset  = 1'b1;
        target = 8'd0;
        rate   = 8'd0;
        step();
        step();

        // ---------------- vector table ----------------
        // Each row gives the inputs held across one edge and the outputs
        // expected just after that edge.
        vecs[0]  = '{1'b1, 8'd0, 8'd0, 8'd0, 1'b1};
        vecs[1]  = '{1'b0, 8'd3, 8'd0, 8'd0, 1'b1};  // target_q takes 3
        vecs[2]  = '{1'b0, 8'd3, 8'd0, 8'd0, 1'b0};  // state leaves IDLE
        vecs[3]  = '{1'b0, 8'd3, 8'd0, 8'd1, 1'b0};
        vecs[4]  = '{1'b0, 8'd3, 8'd0, 8'd2, 1'b0};
        vecs[5]  = '{1'b0, 8'd3, 8'd0, 8'd3, 1'b0};
        vecs[6]  = '{1'b0, 8'd3, 8'd0, 8'd3, 1'b1};
        vecs[7]  = '{1'b0, 8'd3, 8'd0, 8'd3, 1'b1};
        vecs[8]  = '{1'b0, 8'd1, 8'd1, 8'd3, 1'b1};  // down at rate 1
        vecs[9]  = '{1'b0, 8'd1, 8'd1, 8'd3, 1'b0};
        vecs[10] = '{1'b0, 8'd1, 8'd1, 8'd3, 1'b0};
        vecs[11] = '{1'b0, 8'd1, 8'd1, 8'd2, 1'b0};
        vecs[12] = '{1'b0, 8'd1, 8'd1, 8'd2, 1'b0};
        vecs[13] = '{1'b0, 8'd1, 8'd1, 8'd1, 1'b0};
        vecs[14] = '{1'b0, 8'd1, 8'd1, 8'd1, 1'b1};
        vecs[15] = '{1'b0, 8'd1, 8'd1, 8'd1, 1'b1};

        prev_exp = 8'd0;
        for (int i = 0; i < 16; i++) begin
            reset  = vecs[i].rst;
            target = vecs[i].tgt;
            rate   = vecs[i].rt;
            step();
`ifdef LEVEL_SLEW_GAMMA_EN
            exp_pwm = vecs[i].rst ? 0 : int'(gamma(prev_exp));
`else
            exp_pwm = int'(vecs[i].lvl);
`endif
            check($sformatf("vec%0d level", i), int'(level), int'(vecs[i].lvl));
            check($sformatf("vec%0d settled", i), int'(settled), int'(vecs[i].stl));
            check($sformatf("vec%0d pwm", i), int'(pwm_level), exp_pwm);
            prev_exp = vecs[i].lvl;
        end
        reset = 1'b0;

        // ---------------- slow ramp down: 10 -> 8 at rate 3 ----------------
        rate   = 8'd0;
        target = 8'd10;
        wait_level(8'd10, 40, ok);
        check("reach10", int'(ok), 1);
        step();
        step();
        check("settled at 10", int'(settled), 1);
        rate   = 8'd3;
        target = 8'd8;
        c9 = -1; c8 = -1; cs = -1; stl_at_c8 = -1;
        for (int i = 1; i <= 30; i++) begin
            step();
            if (level == 8'd9 && c9 < 0) c9 = i;
            if (level == 8'd8 && c8 < 0) begin
                c8 = i;
                stl_at_c8 = int'(settled);
            end
            if (c8 >= 0 && i > c8 && settled && cs < 0) cs = i;
        end
        check("slow first step edge", c9, 6);
        check("slow step spacing", c8 - c9, 4);
        check("slow settled low at 8", stl_at_c8, 0);
        check("slow settled rise", cs, c8 + 1);
        check("slow final level", int'(level), 8);

        // ---------------- reversal ----------------
        rate = 8'd0;
        do_reset();
        target = 8'd200;
        wait_level(8'd5, 20, ok);
        check("reach5", int'(ok), 1);
        target = 8'd2;
        prev = level; maxl = int'(level); viol = 0; falling = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (int'(level) > maxl) maxl = int'(level);
            if (level < prev) falling = 1'b1;
            if (falling && level > prev) viol++;
            prev = level;
        end
        check("reversal peak", int'(maxl <= 6), 1);
        check("reversal monotonic", viol, 0);
        check("reversal final", int'(level), 2);
        check("reversal settled", int'(settled), 1);

        // ---------------- rails ----------------
        target = 8'd255;
        prev = level; viol = 0;
        for (int i = 0; i < 270; i++) begin
            step();
            if (level < prev) viol++;
            prev = level;
        end
        check("up rail no wrap", viol, 0);
        check("up rail level", int'(level), 255);
        check("up rail settled", int'(settled), 1);
        check("up rail pwm", int'(pwm_level), 255);
        target = 8'd0;
        prev = level; viol = 0;
        for (int i = 0; i < 270; i++) begin
            step();
            if (level > prev) viol++;
            prev = level;
        end
        check("down rail no wrap", viol, 0);
        check("down rail level", int'(level), 0);
        check("down rail settled", int'(settled), 1);
        check("down rail pwm", int'(pwm_level), 0);

        // ---------------- reset mid-ramp ----------------
        target = 8'd200;
        wait_level(8'd100, 150, ok);
        check("reach100", int'(ok), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midreset level", int'(level), 0);
        check("midreset settled", int'(settled), 1);
        check("midreset pwm", int'(pwm_level), 0);
        wait_level(8'd200, 250, ok);
        check("resume to 200", int'(ok), 1);

        // ---------------- pwm_level mapping ----------------
        do_reset();
        target = 8'd16;
        wait_level(8'd16, 40, ok);
        check("reach16", int'(ok), 1);
`ifdef LEVEL_SLEW_GAMMA_EN
        check("pwm at 16 lag", int'(pwm_level), 0);
        step();
        check("pwm at 16", int'(pwm_level), 1);
`else
        check("pwm at 16 lag", int'(pwm_level), 16);
        step();
        check("pwm at 16", int'(pwm_level), 16);
`endif
        target = 8'd128;
        wait_level(8'd128, 200, ok);
        check("reach128", int'(ok), 1);
`ifdef LEVEL_SLEW_GAMMA_EN
        check("pwm at 128 lag", int'(pwm_level), 63);
        step();
        check("pwm at 128", int'(pwm_level), 64);
`else
        check("pwm at 128 lag", int'(pwm_level), 128);
        step();
        check("pwm at 128", int'(pwm_level), 128);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
